bcd_conv_scheduler: RTL and testbench

// - Sequences the shared serial binary-to-BCD converter over every element of the matrix result buffer.
// - Per element: reads the value, range-checks it, runs one conversion, writes 4-digit BCD to the display buffer.
// - Sits between the matrix-product RAM (read side), one converter instance, and the display/7-seg buffer (write side).

---
 rtl/bcd_sched_pkg.sv | 22 ++
 rtl/bcd_sched_watchdog.sv | 33 +++
 rtl/bcd_conv_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
package bcd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_OVF   = 3'd5,
    ST_WRITE = 3'd6,
    ST_FIN   = 3'd7
  } state_t;

  // Largest value that fits in four BCD digits (9999).
  localparam logic [15:0] BCD_MAX  = 16'h270F;
  // Display code for a value that cannot be shown in four digits.
  localparam logic [15:0] OVF_CODE = 16'hFFFF;
  // Display code for a conversion the converter never answered.
  localparam logic [15:0] ERR_CODE = 16'hEEEE;

endpackage

// File: rtl/bcd_sched_watchdog.sv
// WAIT-state watchdog for the BCD scheduler: a down-counter loaded when a
// conversion is launched and a terminal-count compare. Only instantiated
// when BCD_SCHED_TIMEOUT_EN is defined.
module bcd_sched_watchdog #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Loaded with TIMEOUT_CYC-1 so the compare fires on the TIMEOUT_CYC-th run cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Reload on conversion launch, count down while the FSM is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = run && (count == '0);

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Walks every element of the matrix result RAM, range-checks it, runs it
// through the shared serial binary-to-BCD converter and writes the digits
// (or a code word) into the display buffer.
// Optional macro BCD_SCHED_TIMEOUT_EN adds a WAIT watchdog and a sticky
// conv_err output.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no frame in progress; starts on refresh_req or pending request
// FETCH  | rd_en high, rd_addr = idx
// LATCH  | rd_data valid; range check, load conv_bin or flag overflow
// START  | conv_start high for one cycle
// WAIT   | waiting for conv_done (or watchdog expiry when enabled)
// OVF    | value > 9999: load blank code, converter not started
// WRITE  | wr_en high, wr_addr = idx; advance idx or finish frame
// FIN    | frame_done high for one cycle
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_ELEM    = 9,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                refresh_req,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [15:0]         rd_data,
  output logic                conv_start,
  output logic [15:0]         conv_bin,
  input  logic                conv_done,
  input  logic [15:0]         conv_bcd,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [15:0]         wr_data,
  output logic                busy,
  output logic                frame_done,
  output logic [NUM_ELEM-1:0] ovf_flags
`ifdef BCD_SCHED_TIMEOUT_EN
  ,
  output logic                conv_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ELEM - 1);

  // Elaboration-time sanity check on the parameter set.
  if (((2 ** ADDR_W) < NUM_ELEM) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("bcd_conv_scheduler: ADDR_W too small for NUM_ELEM or TIMEOUT_CYC < 1");
  end

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              pending;

`ifdef BCD_SCHED_TIMEOUT_EN
  logic wd_expired;

  bcd_sched_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_START),
    .run    (state == ST_WAIT),
    .expired(wd_expired)
  );
`endif

  // Frame sequencer: state, element index, request merge and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      conv_start <= 1'b0;
      conv_bin   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovf_flags  <= '0;
`ifdef BCD_SCHED_TIMEOUT_EN
      conv_err   <= 1'b0;
`endif
    end else begin
      // Requests arriving mid-frame collapse into a single queued frame.
      if (refresh_req && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (refresh_req || pending) begin
            idx       <= '0;
            ovf_flags <= '0;
            pending   <= 1'b0;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          rd_en <= 1'b0;
          state <= ST_LATCH;
        end

        ST_LATCH: begin
          if (rd_data > BCD_MAX) begin
            ovf_flags[idx] <= 1'b1;
            state          <= ST_OVF;
          end else begin
            conv_bin   <= rd_data;
            conv_start <= 1'b1;
            state      <= ST_START;
          end
        end

        ST_START: begin
          conv_start <= 1'b0;
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (conv_done) begin
            wr_data <= conv_bcd;
            wr_en   <= 1'b1;
            wr_addr <= idx;
            state   <= ST_WRITE;
          end
`ifdef BCD_SCHED_TIMEOUT_EN
          else if (wd_expired) begin
            wr_data  <= ERR_CODE;
            wr_en    <= 1'b1;
            wr_addr  <= idx;
            conv_err <= 1'b1;
            state    <= ST_WRITE;
          end
`endif
        end

        ST_OVF: begin
          wr_data <= OVF_CODE;
          wr_en   <= 1'b1;
          wr_addr <= idx;
          state   <= ST_WRITE;
        end

        ST_WRITE: begin
          wr_en <= 1'b0;
          if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            state      <= ST_FIN;
          end else begin
            idx     <= idx + 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= idx + 1'b1;
            state   <= ST_FETCH;
          end
        end

        ST_FIN: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Testbench for bcd_conv_scheduler: 1-cycle RAM model, 16-cycle converter
// model, write/latency scoreboard against an arithmetic reference model.
// Define BCD_SCHED_TIMEOUT_EN on both RTL and bench to exercise the watchdog.
module tb_bcd_conv_scheduler;

  localparam int NE       = 9;
  localparam int AW       = 4;
  localparam int TO       = 32;
  localparam int CONV_LAT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          refresh_req = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data = 16'h0;
  logic          conv_start;
  logic [15:0]   conv_bin;
  logic          conv_done;
  logic [15:0]   conv_bcd = 16'h0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic [NE-1:0] ovf_flags;
`ifdef BCD_SCHED_TIMEOUT_EN
  logic          conv_err;
`endif

  logic model_done = 1'b0;
  logic spur = 1'b0;
  assign conv_done = model_done | spur;

  bcd_conv_scheduler #(.NUM_ELEM(NE), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_req(refresh_req),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf_flags  (ovf_flags)
`ifdef BCD_SCHED_TIMEOUT_EN
    ,
    .conv_err   (conv_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain decimal digit extraction and display rules.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_word(input int v, input bit dropped);
    if (v > 9999) return 16'hFFFF;
    if (dropped)  return 16'hEEEE;
    return to_bcd(v);
  endfunction

  // Cycles from the element's rd_en to its wr_en.
  function automatic int exp_lat(input int v, input bit dropped);
    if (v > 9999) return 3;
    if (dropped)  return 2 + TO + 1;
    return 2 + CONV_LAT + 1;
  endfunction

  // Cycle counter and environment state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]   ram [NE];
  logic          prev_rd_en = 1'b0;
  logic [AW-1:0] prev_rd_addr = '0;
  int            last_rd_cyc = 0;
  int            n_start = 0;
  int            n_fd = 0;
  int            fd_cyc[$];
  int            rd_cyc[$];
  logic [AW-1:0] w_addr_q[$];
  logic [15:0]   w_data_q[$];
  int            w_lat_q[$];
  bit            conv_pend = 0;
  int            done_at = 0;
  logic [15:0]   conv_cap = 16'h0;
  int            drop_ord = -1;
  int            start_base = 0;

  // RAM model, converter model and write monitor, all on the falling edge.
  always @(negedge clk) begin
    rd_data = prev_rd_en ? ram[prev_rd_addr] : 16'($urandom);
    prev_rd_en = rd_en;
    prev_rd_addr = rd_addr;
    if (rd_en) begin
      rd_cyc.push_back(cyc);
      last_rd_cyc = cyc;
    end

    if (rst) conv_pend = 0;
    if (conv_pend && (cyc == done_at)) begin
      model_done = 1'b1;
      conv_bcd = to_bcd(int'(conv_cap));
      check("conv_bin_hold", conv_bin, conv_cap);
      conv_pend = 0;
    end else begin
      model_done = 1'b0;
      conv_bcd = 16'($urandom);
    end
    if (conv_start) begin
      if ((n_start - start_base) != drop_ord) begin
        conv_pend = 1;
        done_at = cyc + CONV_LAT;
        conv_cap = conv_bin;
      end
      n_start++;
    end

    if (wr_en) begin
      w_addr_q.push_back(wr_addr);
      w_data_q.push_back(wr_data);
      w_lat_q.push_back(cyc - last_rd_cyc);
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc.push_back(cyc);
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_conv_start"}, conv_start, 0);
    check({tag, "_conv_bin"}, conv_bin, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_ovf_flags"}, ovf_flags, 0);
`ifdef BCD_SCHED_TIMEOUT_EN
    check({tag, "_conv_err"}, conv_err, 0);
`endif
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic wait_fd(input int target, input string tag);
    int k = 0;
    while ((n_fd < target) && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_frame_done_seen"}, (n_fd >= target), 1);
  endtask

  task automatic check_writes(input int wb, input string tag, input int drop_el);
    for (int i = 0; i < NE; i++) begin
      int v;
      bit dr;
      v = int'(ram[i]);
      dr = (i == drop_el);
      if ((wb + i) < w_data_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), w_addr_q[wb+i], i);
        check($sformatf("%s_data%0d", tag, i), w_data_q[wb+i], exp_word(v, dr));
        check($sformatf("%s_lat%0d", tag, i), w_lat_q[wb+i], exp_lat(v, dr));
      end else begin
        check($sformatf("%s_missing_wr%0d", tag, i), 0, 1);
      end
    end
  endtask

  function automatic logic [NE-1:0] exp_ovf();
    logic [NE-1:0] e;
    for (int i = 0; i < NE; i++) e[i] = (ram[i] > 16'd9999);
    return e;
  endfunction

  function automatic int exp_starts();
    int n = 0;
    for (int i = 0; i < NE; i++) if (ram[i] <= 16'd9999) n++;
    return n;
  endfunction

  // One full frame; drop_el is the element whose conversion is never answered
  // (callers keep all earlier elements in range so it is also the start ordinal).
  task automatic run_frame(input int drop_el, input bit spur_fetch, input string tag);
    int wb;
    int sb;
    int fb;
    wb = w_data_q.size();
    sb = n_start;
    fb = n_fd;
    start_base = sb;
    drop_ord = drop_el;
    pulse_refresh();
    if (spur_fetch) begin
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
    end
    check({tag, "_busy_run"}, busy, 1);
    wait_fd(fb + 1, tag);
    repeat (2) @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_n_writes"}, w_data_q.size() - wb, NE);
    check_writes(wb, tag, drop_el);
    check({tag, "_n_frame_done"}, n_fd - fb, 1);
    check({tag, "_n_conv_start"}, n_start - sb, exp_starts());
    check({tag, "_ovf_flags"}, ovf_flags, exp_ovf());
    drop_ord = -1;
  endtask

  initial begin
    int wb;
    int sb;
    int fb;
    int k;
    int gap;
    for (int i = 0; i < NE; i++) ram[i] = 16'h0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Ramp 0..8
    for (int i = 0; i < NE; i++) ram[i] = 16'(i);
    run_frame(-1, 0, "ramp");

    // 9999 converts, 10000 blanks
    for (int i = 0; i < NE; i++) ram[i] = 16'($urandom_range(0, 9999));
    ram[0] = 16'd0;
    ram[3] = 16'd9999;
    ram[4] = 16'd10000;
    run_frame(-1, 0, "bound");
    check("bound_ovf_literal", ovf_flags, 9'b000010000);

    // Random mixes of in-range and overflow values
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NE; i++)
        ram[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 9999))
                                             : 16'($urandom_range(0, 65535));
      run_frame(-1, 0, $sformatf("rand%0d", f));
    end

    // Spurious conv_done in IDLE, then in FETCH
    wb = w_data_q.size();
    fb = n_fd;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (4) @(negedge clk);
    check("spur_idle_no_write", w_data_q.size() - wb, 0);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_no_fd", n_fd - fb, 0);
    for (int i = 0; i < NE; i++) ram[i] = 16'($urandom_range(0, 9999));
    run_frame(-1, 1, "spur_fetch");

    // Three requests during one frame -> exactly two frames
    for (int i = 0; i < NE; i++) ram[i] = 16'($urandom_range(0, 9999));
    wb = w_data_q.size();
    sb = n_start;
    fb = n_fd;
    start_base = sb;
    pulse_refresh();
    repeat (30) @(negedge clk);
    pulse_refresh();
    repeat (20) @(negedge clk);
    pulse_refresh();
    wait_fd(fb + 2, "pend");
    repeat (300) @(negedge clk);
    check("pend_n_frame_done", n_fd - fb, 2);
    check("pend_n_writes", w_data_q.size() - wb, 2 * NE);
    check("pend_n_conv_start", n_start - sb, 2 * NE);
    check("pend_busy_after", busy, 0);
    check_writes(wb, "pend_f0", -1);
    check_writes(wb + NE, "pend_f1", -1);
    gap = -1;
    if (fd_cyc.size() > fb) begin
      k = 0;
      while ((k < rd_cyc.size()) && (rd_cyc[k] <= fd_cyc[fb])) k++;
      if (k < rd_cyc.size()) gap = rd_cyc[k] - fd_cyc[fb];
    end
    check("pend_restart_gap", gap, 2);

`ifdef BCD_SCHED_TIMEOUT_EN
    // Converter never answers element 2
    check("to_conv_err_before", conv_err, 0);
    for (int i = 0; i < NE; i++) ram[i] = 16'($urandom_range(0, 9999));
    run_frame(2, 0, "timeout");
    check("to_conv_err_after", conv_err, 1);
`endif

    // Reset while waiting on element 5
    for (int i = 0; i < NE; i++) ram[i] = 16'($urandom_range(0, 9999));
    wb = w_data_q.size();
    sb = n_start;
    fb = n_fd;
    start_base = sb;
    pulse_refresh();
    k = 0;
    while ((n_start < sb + 6) && (k < 1000)) begin
      @(negedge clk);
      k++;
    end
    check("rstw_reached_elem5", (n_start >= sb + 6), 1);
    repeat (5) @(negedge clk);
    check("rstw_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rstw");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rstw_n_writes", w_data_q.size() - wb, 5);
    check("rstw_no_fd", n_fd - fb, 0);
    check("rstw_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
